// File: rtl/gc_ref_pkg.sv
// Shared types and default geometry for the per-bank gain-cell refresh engine.
package gc_ref_pkg;

    localparam int ROWS_DEF   = 128;
    localparam int ADDR_W_DEF = 7;
    localparam int DATA_W_DEF = 64;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        WRITE,
        DONE
    } ref_state_t;

endpackage

// File: rtl/ref_row_counter.sv
// Row address counter for the refresh sweep: synchronous clear, enable, and a
// flag marking the final row of the bank.
module ref_row_counter
    import gc_ref_pkg::*;
#(
    parameter int ROWS   = ROWS_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              en,
    output logic [ADDR_W-1:0] count,
    output logic              last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + ADDR_W'(1);
        end
    end

    assign last = (count == ADDR_W'(ROWS - 1));

endmodule

// File: rtl/bank_refresh_engine.sv
// Per-bank refresh sequencer: read-then-write-back sweep over every row, arbitrated
// against user traffic. Define BANK_REF_STATS_EN to add the stall_cnt statistics port.
module bank_refresh_engine
    import gc_ref_pkg::*;
#(
    parameter int ROWS   = ROWS_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              u_we,
    input  logic              u_re,
    input  logic [ADDR_W-1:0] u_waddr,
    input  logic [ADDR_W-1:0] u_raddr,
    input  logic [DATA_W-1:0] u_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_we,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              ref_done,
    output logic              offs_ref_re,
    output logic              busy
`ifdef BANK_REF_STATS_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    ref_state_t        state;
    logic [ADDR_W-1:0] row;
    logic              last;
    logic [DATA_W-1:0] hold;
    logic              skip;

    logic accept;
    logic ref_rd;
    logic ref_wr_slot;
    logic ref_wr;
    logic user_hit;

    assign accept      = (state == IDLE) && start;
    assign ref_rd      = (state == READ) && !u_re;
    assign ref_wr_slot = (state == WRITE) && !u_we;
    assign ref_wr      = ref_wr_slot && !skip;
    assign user_hit    = u_we && (u_waddr == row) &&
                         ((state == READ) || (state == WAIT) || (state == WRITE));

    ref_row_counter #(
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_row_counter (
        .clk   (clk),
        .rst   (rst),
        .clear (accept),
        .en    (ref_wr_slot && !last),
        .count (row),
        .last  (last)
    );

    // A user write landing on the row in flight makes the held copy stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            ref_done <= 1'b0;
            hold     <= '0;
            skip     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= READ;
                        ref_done <= 1'b0;
                        skip     <= 1'b0;
                    end
                end
                READ: begin
                    if (user_hit) skip <= 1'b1;
                    if (!u_re) state <= WAIT;
                end
                WAIT: begin
                    hold  <= mem_rdata;
                    if (user_hit) skip <= 1'b1;
                    state <= WRITE;
                end
                WRITE: begin
                    if (u_we) begin
                        if (user_hit) skip <= 1'b1;
                    end else begin
                        skip <= 1'b0;
                        if (last) begin
                            state    <= DONE;
                            ref_done <= 1'b1;
                        end else begin
                            state <= READ;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Refresh takes only the port it needs this cycle; the other always passes through.
    assign busy        = (state != IDLE);
    assign offs_ref_re = ref_rd;
    assign mem_re      = !rst && (u_re || ref_rd);
    assign mem_raddr   = rst ? '0 : (ref_rd ? row : u_raddr);
    assign mem_we      = !rst && (u_we || ref_wr);
    assign mem_waddr   = rst ? '0 : (ref_wr_slot ? row : u_waddr);
    assign mem_wdata   = rst ? '0 : (ref_wr_slot ? hold : u_wdata);

`ifdef BANK_REF_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (accept) begin
            stall_cnt <= '0;
        end else if ((((state == READ) && u_re) || ((state == WRITE) && u_we)) &&
                     (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_bank_refresh_engine.sv
// Self-checking bench for bank_refresh_engine: pass-through vector table plus
// scoreboarded refresh sweeps against a behavioural macro model.
module tb_bank_refresh_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        u_we = 1'b0;
    logic        u_re = 1'b0;
    logic [6:0]  u_waddr = '0;
    logic [6:0]  u_raddr = '0;
    logic [63:0] u_wdata = '0;
    logic [63:0] mem_rdata;
    logic        mem_we;
    logic        mem_re;
    logic [6:0]  mem_waddr;
    logic [6:0]  mem_raddr;
    logic [63:0] mem_wdata;
    logic        ref_done;
    logic        offs_ref_re;
    logic        busy;
`ifdef BANK_REF_STATS_EN
    logic [15:0] stall_cnt;
`endif

    bank_refresh_engine dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .u_we        (u_we),
        .u_re        (u_re),
        .u_waddr     (u_waddr),
        .u_raddr     (u_raddr),
        .u_wdata     (u_wdata),
        .mem_rdata   (mem_rdata),
        .mem_we      (mem_we),
        .mem_re      (mem_re),
        .mem_waddr   (mem_waddr),
        .mem_raddr   (mem_raddr),
        .mem_wdata   (mem_wdata),
        .ref_done    (ref_done),
        .offs_ref_re (offs_ref_re),
        .busy        (busy)
`ifdef BANK_REF_STATS_EN
        ,
        .stall_cnt   (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;
        int          cyc;
        logic [6:0]  addr;
        logic [63:0] data;
    } ev_t;

    typedef struct {
        logic        we;
        logic        re;
        logic [6:0]  waddr;
        logic [6:0]  raddr;
        logic [63:0] wdata;
        logic        exp_we;
        logic        exp_re;
        logic [6:0]  exp_waddr;
        logic [6:0]  exp_raddr;
        logic [63:0] exp_wdata;
    } vec_t;

    localparam int EV_READ  = 0;
    localparam int EV_WRITE = 1;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   t0 = 0;
    int   prev_rises = 0;
    int   done_rises = 0;
    int   done_cyc = 0;
    logic done_q = 1'b0;
    logic mon_en = 1'b0;
    ev_t  exp_q[$];

    logic [63:0] mem [128];
    logic [63:0] rdata_q = '0;
    logic        load_req = 1'b0;
    int          mem_seed = 0;

    function automatic logic [63:0] pat(input int r, input int seed);
        return {32'(seed) ^ 32'hC0DE0000, 32'(r) * 32'h9E3779B1};
    endfunction

    // Behavioural macro: registered read data, one cycle after mem_re.
    always @(posedge clk) begin
        if (load_req) begin
            for (int r = 0; r < 128; r++) mem[r] <= pat(r, mem_seed);
        end else if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        if (mem_re) rdata_q <= mem[mem_raddr];
    end
    assign mem_rdata = rdata_q;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic scoreEvent(input int kind, input logic [6:0] addr, input logic [63:0] data);
        ev_t e;
        int  rel;
        rel = cyc - t0;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_access: kind %0d rel cycle %0d addr %0d data %h, expected none",
                     kind, rel, addr, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != rel || e.addr !== addr || e.data !== data) begin
                errors++;
                $display("[TB] FAIL access: got kind %0d cyc %0d addr %0d data %h, expected kind %0d cyc %0d addr %0d data %h",
                         kind, rel, addr, data, e.kind, e.cyc, e.addr, e.data);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (offs_ref_re) scoreEvent(EV_READ, mem_raddr, 64'd0);
            if (mem_we) scoreEvent(EV_WRITE, mem_waddr, mem_wdata);
        end
        if (ref_done && !done_q) begin
            done_rises <= done_rises + 1;
            done_cyc   <= cyc;
        end
        done_q <= ref_done;
    end

    task automatic pushEv(input int kind, input int rel, input int addr, input logic [63:0] data);
        ev_t e;
        e.kind = kind;
        e.cyc  = rel;
        e.addr = 7'(addr);
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic we, input logic re, input logic [6:0] waddr,
                                 input logic [6:0] raddr, input logic [63:0] wdata);
        u_we    = we;
        u_re    = re;
        u_waddr = waddr;
        u_raddr = raddr;
        u_wdata = wdata;
    endtask

    task automatic gotoCycle(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic loadMem(input int seed);
        mem_seed = seed;
        load_req = 1'b1;
        @(posedge clk);
        #1;
        load_req = 1'b0;
    endtask

    task automatic startSweep();
        prev_rises = done_rises;
        t0 = cyc;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(input string name, input int exp_rel);
        int budget;
        budget = 0;
        while (done_rises == prev_rises && budget < 600) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (done_rises == prev_rises) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: ref_done never rose within 600 cycles, expected at +%0d", name, exp_rel);
        end else begin
            checkOutput(name, 64'(done_cyc - t0), 64'(exp_rel));
            @(negedge clk);
            checkOutput({name, "_busy_after"}, 64'(busy), 64'd0);
            checkOutput({name, "_done_held"}, 64'(ref_done), 64'd1);
        end
        checkOutput({name, "_queue_empty"}, 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "_busy"}, 64'(busy), 64'd0);
        checkOutput({name, "_ref_done"}, 64'(ref_done), 64'd0);
        checkOutput({name, "_offs_ref_re"}, 64'(offs_ref_re), 64'd0);
        checkOutput({name, "_mem_we"}, 64'(mem_we), 64'd0);
        checkOutput({name, "_mem_re"}, 64'(mem_re), 64'd0);
        checkOutput({name, "_mem_waddr"}, 64'(mem_waddr), 64'd0);
        checkOutput({name, "_mem_raddr"}, 64'(mem_raddr), 64'd0);
        checkOutput({name, "_mem_wdata"}, mem_wdata, 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[4];
        logic [63:0] d4;

        vecs[0] = '{1'b1, 1'b0, 7'd5,   7'd9,   64'h1111_2222_3333_4444,
                    1'b1, 1'b0, 7'd5,   7'd9,   64'h1111_2222_3333_4444};
        vecs[1] = '{1'b0, 1'b1, 7'd3,   7'd100, 64'h0,
                    1'b0, 1'b1, 7'd3,   7'd100, 64'h0};
        vecs[2] = '{1'b1, 1'b1, 7'd127, 7'd0,   64'hFFFF_FFFF_FFFF_FFFF,
                    1'b1, 1'b1, 7'd127, 7'd0,   64'hFFFF_FFFF_FFFF_FFFF};
        vecs[3] = '{1'b0, 1'b0, 7'd64,  7'd33,  64'hDEAD_BEEF_0000_0001,
                    1'b0, 1'b0, 7'd64,  7'd33,  64'hDEAD_BEEF_0000_0001};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkAllZero("reset");
`ifdef BANK_REF_STATS_EN
        checkOutput("reset_stall_cnt", 64'(stall_cnt), 64'd0);
`endif
        rst = 1'b0;
        @(posedge clk);
        #1;

        // IDLE pass-through vectors
        for (int i = 0; i < 4; i++) begin
            applyStimulus(vecs[i].we, vecs[i].re, vecs[i].waddr, vecs[i].raddr, vecs[i].wdata);
            @(negedge clk);
            checkOutput($sformatf("vec%0d_mem_we", i), 64'(mem_we), 64'(vecs[i].exp_we));
            checkOutput($sformatf("vec%0d_mem_re", i), 64'(mem_re), 64'(vecs[i].exp_re));
            checkOutput($sformatf("vec%0d_mem_waddr", i), 64'(mem_waddr), 64'(vecs[i].exp_waddr));
            checkOutput($sformatf("vec%0d_mem_raddr", i), 64'(mem_raddr), 64'(vecs[i].exp_raddr));
            checkOutput($sformatf("vec%0d_mem_wdata", i), mem_wdata, vecs[i].exp_wdata);
            checkOutput($sformatf("vec%0d_offs_ref_re", i), 64'(offs_ref_re), 64'd0);
            checkOutput($sformatf("vec%0d_busy", i), 64'(busy), 64'd0);
            @(posedge clk);
            #1;
        end
        applyStimulus(1'b0, 1'b0, 7'd0, 7'd0, 64'd0);
        mon_en = 1'b1;

        // Plain sweep
        $display("[TB] sweep without user traffic");
        loadMem(1);
        for (int r = 0; r < 128; r++) begin
            pushEv(EV_READ, 1 + 3 * r, r, 64'd0);
            pushEv(EV_WRITE, 3 + 3 * r, r, pat(r, 1));
        end
        startSweep();
        waitDone("plain_done_cycle", 385);

        // Five-cycle read stall on row 10
        $display("[TB] read stall on row 10");
        loadMem(2);
        for (int r = 0; r < 128; r++) begin
            pushEv(EV_READ, 1 + 3 * r + ((r >= 10) ? 5 : 0), r, 64'd0);
            pushEv(EV_WRITE, 3 + 3 * r + ((r >= 10) ? 5 : 0), r, pat(r, 2));
        end
        startSweep();
        gotoCycle(t0 + 31);
        applyStimulus(1'b0, 1'b1, 7'd0, 7'd77, 64'd0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("stall_offs_ref_re", 64'(offs_ref_re), 64'd0);
            checkOutput("stall_user_mem_re", 64'(mem_re), 64'd1);
            checkOutput("stall_user_mem_raddr", 64'(mem_raddr), 64'd77);
            @(posedge clk);
            #1;
        end
        applyStimulus(1'b0, 1'b0, 7'd0, 7'd0, 64'd0);
        waitDone("stall_done_cycle", 390);
`ifdef BANK_REF_STATS_EN
        checkOutput("stall_cnt_after_stalls", 64'(stall_cnt), 64'd5);
`endif

        // User write to row 20 during its WAIT cancels the write-back
        $display("[TB] user write to row 20 in WAIT");
        loadMem(3);
        for (int r = 0; r < 128; r++) begin
            pushEv(EV_READ, 1 + 3 * r, r, 64'd0);
            if (r == 20) pushEv(EV_WRITE, 62, 20, 64'hA5A5_A5A5_A5A5_A5A5);
            else         pushEv(EV_WRITE, 3 + 3 * r, r, pat(r, 3));
        end
        startSweep();
`ifdef BANK_REF_STATS_EN
        @(negedge clk);
        checkOutput("stall_cnt_cleared", 64'(stall_cnt), 64'd0);
        @(posedge clk);
        #1;
`endif
        gotoCycle(t0 + 62);
        applyStimulus(1'b1, 1'b0, 7'd20, 7'd0, 64'hA5A5_A5A5_A5A5_A5A5);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 7'd0, 7'd0, 64'd0);
        waitDone("skip_done_cycle", 385);
        checkOutput("skip_row20_contents", mem[20], 64'hA5A5_A5A5_A5A5_A5A5);

        // User write to row 21 during WRITE of row 20 stalls the write-back one cycle
        $display("[TB] user write to row 21 in WRITE of row 20");
        d4 = 64'h0123_4567_89AB_CDEF;
        loadMem(4);
        for (int r = 0; r < 128; r++) begin
            if (r < 20) begin
                pushEv(EV_READ, 1 + 3 * r, r, 64'd0);
                pushEv(EV_WRITE, 3 + 3 * r, r, pat(r, 4));
            end else if (r == 20) begin
                pushEv(EV_READ, 61, 20, 64'd0);
                pushEv(EV_WRITE, 63, 21, d4);
                pushEv(EV_WRITE, 64, 20, pat(20, 4));
            end else begin
                pushEv(EV_READ, 2 + 3 * r, r, 64'd0);
                pushEv(EV_WRITE, 4 + 3 * r, r, (r == 21) ? d4 : pat(r, 4));
            end
        end
        startSweep();
        gotoCycle(t0 + 63);
        applyStimulus(1'b1, 1'b0, 7'd21, 7'd0, d4);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 1'b0, 7'd0, 7'd0, 64'd0);
        waitDone("wstall_done_cycle", 386);

        // Ignored start mid-sweep, then reset at row 64
        $display("[TB] mid-sweep start and reset");
        loadMem(5);
        for (int r = 0; r < 64; r++) begin
            pushEv(EV_READ, 1 + 3 * r, r, 64'd0);
            pushEv(EV_WRITE, 3 + 3 * r, r, pat(r, 5));
        end
        startSweep();
        gotoCycle(t0 + 50);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        gotoCycle(t0 + 193);
        rst = 1'b1;
        #1;
        checkAllZero("midreset");
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("midreset_queue_empty", 64'(exp_q.size()), 64'd0);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        checkOutput("postreset_busy", 64'(busy), 64'd0);

        // Fresh sweep after reset starts at row 0
        $display("[TB] sweep after reset");
        loadMem(6);
        for (int r = 0; r < 128; r++) begin
            pushEv(EV_READ, 1 + 3 * r, r, 64'd0);
            pushEv(EV_WRITE, 3 + 3 * r, r, pat(r, 6));
        end
        startSweep();
        waitDone("restart_done_cycle", 385);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
